// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receive/transmit endpoint, oversampled on CLK
//
// Purpose:
//    Oversamples SCK/CS/MOSI on CLK and supports all four CKP/CPH modes.
//    Assembles MSB-first frames of WIDTH bits and presents each completed frame
//    on RXDATA with a one-cycle RXVALID strobe. It also shifts TXDATA out on MISO.
//
// Ports:
//    CLK      in   system clock (SCK must be <= CLK/4)
//    RESET    in   asynchronous active-high reset
//    CKP      in   SCK idle level, captured at frame start
//    CPH      in   0 = sample on leading edge, 1 = sample on trailing edge
//    SCK      in   serial clock from the master (asynchronous)
//    CS       in   chip select, active low
//    MOSI     in   serial data from the master
//    TXDATA   in   word returned on MISO, latched at frame start / frame wrap
//    MISO     out  serial data to the master
//    RXDATA   out  last completed received frame
//    RXVALID  out  one-cycle pulse when RXDATA updates
//    BUSY     out  high while a frame is in progress
//    ABORT    out  one-cycle pulse when CS rises mid-frame
module spi_slave_rx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CKP,
   input  logic             CPH,
   input  logic             SCK,
   input  logic             CS,
   input  logic             MOSI,
   input  logic [WIDTH-1:0] TXDATA,
   output logic             MISO,
   output logic [WIDTH-1:0] RXDATA,
   output logic             RXVALID,
   output logic             BUSY,
   output logic             ABORT
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
   state_t w_next;
   state_t r_state;

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   // Marks which synchronizer stages hold real pin samples rather than reset fill.
   logic [SYNC_STAGES-1:0] r_real;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic                   r_armed;
   logic                   r_ckp;
   logic                   r_cph;
   logic [CW-1:0]          r_cnt;
   logic [WIDTH-2:0]       r_rx_shift;
   logic [WIDTH-1:0]       r_tx_shift;

   logic             w_sck;
   logic             w_cs;
   logic             w_mosi;
   logic             w_cs_fall;
   logic             w_cs_rise;
   logic             w_lead;
   logic             w_trail;
   logic             w_sample_edge;
   logic             w_drive_edge;
   logic             w_start;
   logic             w_stop;
   logic             w_abort;
   logic             w_sample;
   logic             w_done;
   logic             w_drive;
   logic [WIDTH-1:0] w_rx_next;

   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // A falling CS is accepted only after a genuine high has been observed since
   // reset, so a CS held low across reset does not start a bogus frame.
   assign w_cs_fall = r_armed & r_cs_prev & ~w_cs;
   assign w_cs_rise = ~r_cs_prev & w_cs;

   assign w_lead  = (r_sck_prev == r_ckp) && (w_sck != r_ckp);
   assign w_trail = (r_sck_prev != r_ckp) && (w_sck == r_ckp);

   assign w_sample_edge = r_cph ? w_trail : w_lead;
   assign w_drive_edge  = r_cph ? w_lead  : w_trail;

   assign w_rx_next = {r_rx_shift, w_mosi};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // CS rise has priority over any SCK edge detected in the same cycle.
   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_stop   = 1'b0;
      w_abort  = 1'b0;
      w_sample = 1'b0;
      w_done   = 1'b0;
      w_drive  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_next  = ST_SHIFT;
               w_start = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_next  = ST_IDLE;
               w_stop  = 1'b1;
               w_abort = (r_cnt != '0);
            end else if (w_sample_edge) begin
               w_sample = 1'b1;
               w_done   = (r_cnt == LAST);
            end else if (w_drive_edge) begin
               w_drive = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sck_sync  <= {SYNC_STAGES{CKP}};
         r_cs_sync   <= {SYNC_STAGES{1'b1}};
         r_mosi_sync <= '0;
         r_real      <= '0;
         r_sck_prev  <= CKP;
         r_cs_prev   <= 1'b1;
         r_armed     <= 1'b0;
         r_ckp       <= 1'b0;
         r_cph       <= 1'b0;
         r_cnt       <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         MISO        <= 1'b0;
         RXDATA      <= '0;
         RXVALID     <= 1'b0;
         BUSY        <= 1'b0;
         ABORT       <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_real      <= {r_real[SYNC_STAGES-2:0], 1'b1};
         r_sck_prev  <= w_sck;
         r_cs_prev   <= w_cs;
         if (w_cs && r_real[SYNC_STAGES-1]) r_armed <= 1'b1;
         RXVALID <= 1'b0;
         ABORT   <= w_abort;

         if (w_start) begin
            r_ckp      <= CKP;
            r_cph      <= CPH;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            BUSY       <= 1'b1;
            // CPH=0 has no drive edge ahead of the first sample, so the MSB goes out now.
            if (!CPH) begin
               MISO       <= TXDATA[WIDTH-1];
               r_tx_shift <= {TXDATA[WIDTH-2:0], 1'b0};
            end else begin
               r_tx_shift <= TXDATA;
            end
         end else if (w_stop) begin
            r_cnt      <= '0;
            r_rx_shift <= '0;
            MISO       <= 1'b0;
            BUSY       <= 1'b0;
         end else if (w_sample) begin
            r_rx_shift <= w_rx_next[WIDTH-2:0];
            if (w_done) begin
               // Wrap for a back-to-back frame; the next drive edge emits the new MSB.
               r_cnt      <= '0;
               RXDATA     <= w_rx_next;
               RXVALID    <= 1'b1;
               r_tx_shift <= TXDATA;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else if (w_drive) begin
            MISO       <= r_tx_shift[WIDTH-1];
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       CKP;
   logic       CPH;
   logic       SCK;
   logic       CS;
   logic       MOSI;
   logic [7:0] TXDATA;
   logic       MISO;
   logic [7:0] RXDATA;
   logic       RXVALID;
   logic       BUSY;
   logic       ABORT;

   int checks = 0;
   int errors = 0;
   int valid_total = 0;
   int abort_total = 0;
   logic [7:0] rx_log [0:63];

   spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
      .MOSI(MOSI), .TXDATA(TXDATA), .MISO(MISO), .RXDATA(RXDATA),
      .RXVALID(RXVALID), .BUSY(BUSY), .ABORT(ABORT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RXVALID) begin
         rx_log[valid_total[5:0]] = RXDATA;
         valid_total = valid_total + 1;
      end
      if (ABORT) abort_total = abort_total + 1;
   end

   task automatic half();
      repeat (8) @(negedge CLK);
   endtask

   task automatic cs_fall();
      CS = 1'b0;
      half();
   endtask

   task automatic cs_rise();
      half();
      CS = 1'b1;
      half();
   endtask

   task automatic spi_bits(input logic [15:0] data, input int n, output logic [15:0] miso);
      miso = '0;
      for (int i = 0; i < n; i++) begin
         if (!CPH) begin
            MOSI = data[n-1-i];
            half();
            miso = {miso[14:0], MISO};
            SCK = ~CKP;
            half();
            SCK = CKP;
         end else begin
            SCK = ~CKP;
            MOSI = data[n-1-i];
            half();
            miso = {miso[14:0], MISO};
            SCK = CKP;
            half();
         end
      end
   endtask

   task automatic set_mode(input logic ckp, input logic cph);
      CKP = ckp;
      CPH = cph;
      SCK = ckp;
      MOSI = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0; TXDATA = 8'h00;
      repeat (3) @(negedge CLK);
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", MISO); end
      checks++; if (RXDATA !== 8'h00) begin errors++; $display("FAIL reset_rxdata got=%h exp=00", RXDATA); end
      checks++; if (RXVALID !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got=%b exp=0", RXVALID); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (ABORT !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", ABORT); end
      RESET = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_mode(input logic ckp, input logic cph);
      int v0, a0;
      logic [15:0] m;
      set_mode(ckp, cph);
      TXDATA = 8'h3C;
      v0 = valid_total; a0 = abort_total;
      cs_fall();
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mode%0d%0d_busy_high got=%b exp=1", ckp, cph, BUSY); end
      spi_bits(16'h00A5, 8, m);
      cs_rise();
      checks++; if (RXDATA !== 8'hA5) begin errors++; $display("FAIL mode%0d%0d_rxdata got=%h exp=a5", ckp, cph, RXDATA); end
      checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL mode%0d%0d_rxvalid_count got=%0d exp=1", ckp, cph, valid_total - v0); end
      checks++; if (m[7:0] !== 8'h3C) begin errors++; $display("FAIL mode%0d%0d_miso got=%h exp=3c", ckp, cph, m[7:0]); end
      checks++; if (abort_total - a0 !== 0) begin errors++; $display("FAIL mode%0d%0d_no_abort got=%0d exp=0", ckp, cph, abort_total - a0); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mode%0d%0d_busy_low got=%b exp=0", ckp, cph, BUSY); end
   endtask

   task automatic test_back_to_back();
      int v0, a0, i0, i1;
      logic [15:0] m1, m2;
      set_mode(1'b0, 1'b0);
      TXDATA = 8'h55;
      v0 = valid_total; a0 = abort_total;
      cs_fall();
      TXDATA = 8'hAA;
      spi_bits(16'h0012, 8, m1);
      spi_bits(16'h00F0, 8, m2);
      cs_rise();
      i0 = v0 % 64; i1 = (v0 + 1) % 64;
      checks++; if (valid_total - v0 !== 2) begin errors++; $display("FAIL b2b_rxvalid_count got=%0d exp=2", valid_total - v0); end
      checks++; if (rx_log[i0] !== 8'h12) begin errors++; $display("FAIL b2b_frame1 got=%h exp=12", rx_log[i0]); end
      checks++; if (rx_log[i1] !== 8'hF0) begin errors++; $display("FAIL b2b_frame2 got=%h exp=f0", rx_log[i1]); end
      checks++; if (m1[7:0] !== 8'h55) begin errors++; $display("FAIL b2b_miso1 got=%h exp=55", m1[7:0]); end
      checks++; if (m2[7:0] !== 8'hAA) begin errors++; $display("FAIL b2b_miso2 got=%h exp=aa", m2[7:0]); end
      checks++; if (abort_total - a0 !== 0) begin errors++; $display("FAIL b2b_no_abort got=%0d exp=0", abort_total - a0); end
   endtask

   task automatic test_abort();
      int v0, a0;
      logic [15:0] m;
      set_mode(1'b0, 1'b0);
      TXDATA = 8'h00;
      v0 = valid_total; a0 = abort_total;
      cs_fall();
      spi_bits(16'h00FF, 5, m);
      cs_rise();
      checks++; if (abort_total - a0 !== 1) begin errors++; $display("FAIL abort_pulse got=%0d exp=1", abort_total - a0); end
      checks++; if (valid_total - v0 !== 0) begin errors++; $display("FAIL abort_no_rxvalid got=%0d exp=0", valid_total - v0); end
      checks++; if (RXDATA !== 8'hF0) begin errors++; $display("FAIL abort_rxdata_kept got=%h exp=f0", RXDATA); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
      v0 = valid_total;
      cs_fall();
      spi_bits(16'h0081, 8, m);
      cs_rise();
      checks++; if (RXDATA !== 8'h81) begin errors++; $display("FAIL abort_next_frame got=%h exp=81", RXDATA); end
      checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL abort_next_rxvalid got=%0d exp=1", valid_total - v0); end
   endtask

   task automatic test_reset_midframe();
      int v0;
      logic [15:0] m;
      set_mode(1'b0, 1'b0);
      TXDATA = 8'hFF;
      cs_fall();
      spi_bits(16'h0005, 3, m);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (4) @(negedge CLK);
      v0 = valid_total;
      spi_bits(16'h00A5, 8, m);
      half();
      checks++; if (valid_total - v0 !== 0) begin errors++; $display("FAIL rst_mid_no_rxvalid got=%0d exp=0", valid_total - v0); end
      checks++; if (m[7:0] !== 8'h00) begin errors++; $display("FAIL rst_mid_miso got=%h exp=00", m[7:0]); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", BUSY); end
      checks++; if (RXDATA !== 8'h00) begin errors++; $display("FAIL rst_mid_rxdata got=%h exp=00", RXDATA); end
      CS = 1'b1;
      half();
      v0 = valid_total;
      cs_fall();
      spi_bits(16'h007E, 8, m);
      cs_rise();
      checks++; if (RXDATA !== 8'h7E) begin errors++; $display("FAIL rst_mid_next_frame got=%h exp=7e", RXDATA); end
      checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL rst_mid_next_rxvalid got=%0d exp=1", valid_total - v0); end
   endtask

   task automatic test_coincident();
      int v0, a0;
      logic seen;
      logic [15:0] m;
      set_mode(1'b0, 1'b0);
      TXDATA = 8'h00;
      v0 = valid_total; a0 = abort_total;
      cs_fall();
      spi_bits(16'h0005, 3, m);
      MOSI = 1'b1;
      half();
      SCK = 1'b1;
      CS = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge CLK);
         if (ABORT === 1'b1) begin
            seen = 1'b1;
            checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL coinc_busy got=%b exp=0", BUSY); end
         end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL coinc_abort_seen got=%b exp=1", seen); end
      SCK = 1'b0;
      half();
      checks++; if (abort_total - a0 !== 1) begin errors++; $display("FAIL coinc_abort_count got=%0d exp=1", abort_total - a0); end
      checks++; if (valid_total - v0 !== 0) begin errors++; $display("FAIL coinc_no_rxvalid got=%0d exp=0", valid_total - v0); end
      v0 = valid_total;
      cs_fall();
      spi_bits(16'h005A, 8, m);
      cs_rise();
      checks++; if (RXDATA !== 8'h5A) begin errors++; $display("FAIL coinc_next_frame got=%h exp=5a", RXDATA); end
      checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL coinc_next_rxvalid got=%0d exp=1", valid_total - v0); end
   endtask

   initial begin
      test_reset();
      test_mode(1'b0, 1'b0);
      test_mode(1'b0, 1'b1);
      test_mode(1'b1, 1'b0);
      test_mode(1'b1, 1'b1);
      test_back_to_back();
      test_abort();
      test_reset_midframe();
      test_coincident();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
